gen1_dataport: RTL and testbench

Single-port data-memory responder for the gen1 core's load/store bus. Accepts `m_read`/`m_write` requests, inserts a programmable number of wait states, and returns `m_readturn`/`m_writeturn` with read data, so the core's PC-enable gating sees a clean one-cycle grant. Bad accesses raise a fault line that the top level wires to one of the core's `iixr` bits. Sits between the core and an internal word RAM at top level.

---
 rtl/gen1_dataport_pkg.sv | 19 +
 rtl/gen1_dataport_ram.sv | 19 +
 rtl/gen1_dataport.sv | 123 ++++++++++++
 tb/tb_gen1_dataport.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/gen1_dataport_pkg.sv
// Shared types and defaults for the gen1 data-memory responder.
// State encoding, default system-region limit and the address range helper.
package gen1_dataport_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GRANT = 2'd2
  } dp_state_t;

  localparam logic [31:0] SYS_LIMIT_DEFAULT = 32'h0000_0800;
  localparam int          WAIT_CNT_W        = 4;

  // True when no byte-address bit above the word index is set.
  function automatic logic addr_in_range(input logic [31:0] addr, input int depth_log2);
    return (addr >> (depth_log2 + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/gen1_dataport_ram.sv
// Single-port synchronous word RAM behind the gen1 data port; contents are not reset.
module gen1_dataport_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/gen1_dataport.sv
// gen1 load/store responder: wait states, one-cycle read/write grant, access fault.
// Optional protection check enabled by defining GEN1_DATAPORT_PROT_EN.
module gen1_dataport
  import gen1_dataport_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] SYS_LIMIT   = SYS_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_read,
  input  logic        m_write,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_dataout,
  input  logic [3:0]  sysflags,
  output logic [31:0] m_datain,
  output logic        m_readturn,
  output logic        m_writeturn,
  output logic        fault,
  output dp_state_t   dbg_state
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

  dp_state_t               state;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic                    lat_rd, lat_wr, lat_fault;
  logic [DEPTH_LOG2-1:0]   lat_word;
  logic [31:0]             lat_wdata;
  logic                    req, req_fault, prot_fault;
  logic [DEPTH_LOG2-1:0]   ram_addr;
  logic                    ram_we;
  logic [31:0]             ram_rdata;

  // Handshake: the core holds m_read/m_write (the request, "valid") until it sees a
  // one-cycle m_readturn/m_writeturn ("ready"); the request is taken only in IDLE.
  assign req = m_read | m_write;

`ifdef GEN1_DATAPORT_PROT_EN
  logic unused_flags;
  assign unused_flags = ^sysflags[3:1];
  assign prot_fault   = (m_addr < SYS_LIMIT) && !sysflags[0];
`else
  logic unused_sysflags;
  assign unused_sysflags = ^{sysflags, SYS_LIMIT};
  assign prot_fault      = 1'b0;
`endif

  assign req_fault = (m_read & m_write) | (m_addr[1:0] != 2'b00) |
                     !addr_in_range(m_addr, DEPTH_LOG2) | prot_fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      lat_rd      <= 1'b0;
      lat_wr      <= 1'b0;
      lat_fault   <= 1'b0;
      lat_word    <= '0;
      lat_wdata   <= '0;
      m_readturn  <= 1'b0;
      m_writeturn <= 1'b0;
      fault       <= 1'b0;
    end else begin
      m_readturn  <= 1'b0;
      m_writeturn <= 1'b0;
      fault       <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            lat_rd    <= m_read;
            lat_wr    <= m_write;
            lat_fault <= req_fault;
            lat_word  <= m_addr[DEPTH_LOG2+1:2];
            lat_wdata <= m_dataout;
            if (WAIT_CYCLES == 0) begin
              state       <= ST_GRANT;
              m_readturn  <= m_read;
              m_writeturn <= m_write & ~m_read;
              fault       <= req_fault;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          // A dropped or changed request abandons the access before any side effect.
          if ({m_read, m_write} != {lat_rd, lat_wr}) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt == '0) begin
            state       <= ST_GRANT;
            m_readturn  <= lat_rd;
            m_writeturn <= lat_wr & ~lat_rd;
            fault       <= lat_fault;
          end else begin
            wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
          end
        end
        ST_GRANT: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // RAM reads the incoming address in IDLE so zero-wait reads have data at GRANT.
  assign ram_addr  = (state == ST_IDLE) ? m_addr[DEPTH_LOG2+1:2] : lat_word;
  assign ram_we    = (state == ST_GRANT) & m_writeturn & ~fault;
  assign m_datain  = (m_readturn & ~fault) ? ram_rdata : 32'h0;
  assign dbg_state = state;

  gen1_dataport_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (lat_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_gen1_dataport.sv
// Scoreboarded bench for gen1_dataport: directed cases plus randomized traffic.
module tb_gen1_dataport;
  import gen1_dataport_pkg::*;

  localparam int          DEPTH = 12;
  localparam int          W     = 2;
  localparam logic [31:0] SYSL  = 32'h0000_0800;
`ifdef GEN1_DATAPORT_PROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_read = 1'b0, m_write = 1'b0;
  logic [31:0] m_addr = '0, m_dataout = '0;
  logic [3:0]  sysflags = '0;
  logic [31:0] m_datain;
  logic        m_readturn, m_writeturn, fault;
  dp_state_t   dbg_state;

  gen1_dataport #(.DEPTH_LOG2(DEPTH), .WAIT_CYCLES(W), .SYS_LIMIT(SYSL)) dut (
    .clk(clk), .reset(reset), .m_read(m_read), .m_write(m_write), .m_addr(m_addr),
    .m_dataout(m_dataout), .sysflags(sysflags), .m_datain(m_datain),
    .m_readturn(m_readturn), .m_writeturn(m_writeturn), .fault(fault), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {grant cycle[66:35], readturn, writeturn, fault, data[31:0]}
  logic [66:0] exp_q[$];
  logic [31:0] mem_m [int];
  int n_cmp = 0, n_err = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic model_fault(input logic rd, input logic wr, input logic [31:0] a,
                                       input logic [3:0] s);
    logic f;
    f = (rd && wr) || (a % 4 != 0) || (a >= (32'd1 << (DEPTH + 2)));
    if (PROT && a < SYSL && !s[0]) f = 1'b1;
    return f;
  endfunction

  always @(negedge clk) begin
    logic [66:0] e;
    if (!reset && started) begin
      if (m_readturn || m_writeturn) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_grant: rd=%b wr=%b with empty queue (cycle %0d)",
                   m_readturn, m_writeturn, cyc);
        end else begin
          e = exp_q.pop_front();
          check("grant_cycle", cyc, e[66:35]);
          check("readturn", {31'd0, m_readturn}, {31'd0, e[34]});
          check("writeturn", {31'd0, m_writeturn}, {31'd0, e[33]});
          check("fault", {31'd0, fault}, {31'd0, e[32]});
          check("datain", m_datain, e[31:0]);
        end
      end else begin
        check("idle_fault", {31'd0, fault}, 32'd0);
        check("idle_datain", m_datain, 32'd0);
      end
    end
  end

  // driver: b2b = issued during the previous grant cycle; chain = leave request asserted
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] sys, input bit b2b, input bit chain);
    logic f;
    logic [31:0] d;
    int idx;
    int lat;
    m_read = rd; m_write = wr; m_addr = addr; m_dataout = wd; sysflags = sys;
    f   = model_fault(rd, wr, addr, sys);
    idx = int'((addr >> 2) % (32'd1 << DEPTH));
    d   = 32'h0;
    if (rd && !f) d = mem_m[idx];
    if (wr && !rd && !f) mem_m[idx] = wd;
    lat = W + (b2b ? 2 : 1);
    exp_q.push_back({32'(cyc + lat), rd, wr && !rd, f, d});
    repeat (lat) @(negedge clk);
    if (!chain) begin
      m_read = 1'b0; m_write = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] a, base;
    int kind, err;
    bit chain, prev_chain;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_readturn", {31'd0, m_readturn}, 32'd0);
    check("rst_writeturn", {31'd0, m_writeturn}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_datain", m_datain, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    reset = 1'b0; started = 1'b1;
    @(negedge clk);

    // preload the address pools (system region written in system mode)
    for (int k = 0; k < 16; k++) begin
      issue(1'b0, 1'b1, 32'h1000 + 32'(4 * k), $urandom, 4'h1, 1'b0, 1'b0);
      issue(1'b0, 1'b1, 32'h0400 + 32'(4 * k), $urandom, 4'h1, 1'b0, 1'b0);
    end
    issue(1'b0, 1'b1, 32'h0, 32'h1111_1111, 4'h1, 1'b0, 1'b0);

    // write then read back
    issue(1'b0, 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'h1, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 32'h1000, 32'h0, 4'h1, 1'b0, 1'b0);
    // back-to-back reads: each costs W+2 cycles
    for (int k = 0; k < 4; k++)
      issue(1'b1, 1'b0, 32'h1000 + 32'(4 * k), 32'h0, 4'h1, k != 0, k != 3);
    // misaligned read, out-of-range write (aliases word 0), read-both
    issue(1'b1, 1'b0, 32'h1002, 32'h0, 4'h1, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 32'h0010_0000, 32'hBAD0_BAD0, 4'h1, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 32'h0, 32'h0, 4'h1, 1'b0, 1'b0);
    issue(1'b1, 1'b1, 32'h1004, 32'h0, 4'h1, 1'b0, 1'b0);
    // protection region in user then system mode
    issue(1'b0, 1'b1, 32'h0400, 32'h5, 4'h0, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 32'h0400, 32'h0, 4'h1, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 32'h0400, 32'h5, 4'h1, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 32'h0400, 32'h0, 4'h0, 1'b0, 1'b0);

    // write dropped before its grant
    m_write = 1'b1; m_addr = 32'h1000; m_dataout = 32'h0BAD_0001; sysflags = 4'h1;
    repeat (W) @(negedge clk);
    m_write = 1'b0;
    repeat (W + 2) @(negedge clk);
    issue(1'b1, 1'b0, 32'h1000, 32'h0, 4'h1, 1'b0, 1'b0);

    // reset mid-WAIT
    m_write = 1'b1; m_addr = 32'h100C; m_dataout = 32'h0BAD_0002;
    @(negedge clk);
    #2 reset = 1'b1; m_write = 1'b0;
    #1 check("rstwait_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("rstwait_writeturn", {31'd0, m_writeturn}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // reset mid-GRANT of a write: grant seen, write discarded
    m_write = 1'b1; m_addr = 32'h1008; m_dataout = 32'h0BAD_0003;
    exp_q.push_back({32'(cyc + W + 1), 1'b0, 1'b1, 1'b0, 32'h0});
    repeat (W + 1) @(negedge clk);
    #2 reset = 1'b1; m_write = 1'b0;
    #1 check("rstgrant_writeturn", {31'd0, m_writeturn}, 32'd0);
    check("rstgrant_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("rstgrant_datain", m_datain, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    issue(1'b1, 1'b0, 32'h1008, 32'h0, 4'h1, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 32'h100C, 32'h0, 4'h1, 1'b0, 1'b0);

    // randomized traffic
    prev_chain = 1'b0;
    for (int i = 0; i < 60; i++) begin
      base = ($urandom_range(0, 1) == 0) ? 32'h1000 : 32'h0400;
      a    = base + 32'(4 * $urandom_range(0, 15));
      err  = $urandom_range(0, 7);
      if (err == 0) a = a + 32'($urandom_range(1, 3));
      if (err == 1) a = a | 32'h0100_0000;
      kind  = $urandom_range(0, 15);
      chain = (i != 59) && ($urandom_range(0, 2) == 0);
      issue(kind < 8, kind == 0 || kind >= 8, a, $urandom, 4'($urandom_range(0, 15)),
            prev_chain, chain);
      prev_chain = chain;
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
